// File: rtl/noc_ni_param_if.sv
`default_nettype none
// ============================================================================
// noc_ni_param_if -- processor word channels and router flit channels of the NI
// Rev 1.0
// ============================================================================
interface noc_ni_param_if #(
  parameter int DATA_W = 32,
  parameter int FLIT_W = 8,
  parameter int ADDR_W = 2
);
  logic [DATA_W-1:0] tx_data;
  logic [ADDR_W-1:0] tx_dest;
  logic              tx_valid;
  logic              tx_ready;

  logic [FLIT_W-1:0] flit_out;
  logic              flit_out_valid;
  logic              flit_out_ready;

  logic [FLIT_W-1:0] flit_in;
  logic              flit_in_valid;
  logic              flit_in_ready;

  logic [DATA_W-1:0] rx_data;
  logic [ADDR_W-1:0] rx_dest;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_err;

  modport slave (
    input  tx_data, tx_dest, tx_valid, flit_out_ready, flit_in, flit_in_valid, rx_ready,
    output tx_ready, flit_out, flit_out_valid, flit_in_ready, rx_data, rx_dest, rx_valid, rx_err
  );

  modport master (
    output tx_data, tx_dest, tx_valid, flit_out_ready, flit_in, flit_in_valid, rx_ready,
    input  tx_ready, flit_out, flit_out_valid, flit_in_ready, rx_data, rx_dest, rx_valid, rx_err
  );
endinterface
`default_nettype wire

// File: rtl/noc_ni_param.sv
`default_nettype none
// ============================================================================
// noc_ni_param -- word<->flit network interface; NOC_NI_CSUM_EN adds an XOR checksum flit
// Rev 1.0
// ============================================================================
module noc_ni_param #(
  parameter int          DATA_W  = 32,
  parameter int          FLIT_W  = 8,
  parameter int          ADDR_W  = 2,
  parameter int unsigned HDR_TAG = 32'b1011
) (
  input  logic           clk,
  input  logic           rst,
  noc_ni_param_if.slave  bus
);
  localparam int N     = DATA_W / FLIT_W;
  localparam int LEN_W = $clog2(N);
  localparam int T     = FLIT_W - ADDR_W - LEN_W;
  localparam logic [T-1:0]      TAG       = HDR_TAG[T-1:0];
  localparam logic [FLIT_W-1:0] TAIL_FLIT = '1;

  // Index of the highest nonzero flit; trailing zero flits are not sent.
  function automatic logic [LEN_W-1:0] len_m1_of(input logic [DATA_W-1:0] w);
    len_m1_of = '0;
    for (int i = 1; i < N; i++)
      if (w[i*FLIT_W +: FLIT_W] != '0) len_m1_of = LEN_W'(i);
  endfunction

`ifdef NOC_NI_CSUM_EN
  // Unsent flits are zero, so XOR over the whole word equals XOR over the payload.
  function automatic logic [FLIT_W-1:0] xor_flits(input logic [DATA_W-1:0] w);
    xor_flits = '0;
    for (int i = 0; i < N; i++) xor_flits ^= w[i*FLIT_W +: FLIT_W];
  endfunction
`endif

  // ---------------------------------------------------------------- TX path
  typedef enum logic [2:0] {
    TX_IDLE, TX_HEAD, TX_DATA,
`ifdef NOC_NI_CSUM_EN
    TX_CSUM,
`endif
    TX_TAIL
  } tx_state_t;

  tx_state_t         tx_state, tx_next;
  logic [DATA_W-1:0] tx_word;
  logic [FLIT_W-1:0] tx_hdr;
  logic [LEN_W-1:0]  tx_len_m1, tx_cnt;
  logic [LEN_W-1:0]  tx_len_new;
  logic [FLIT_W-1:0] tx_hdr_new;
`ifdef NOC_NI_CSUM_EN
  logic [FLIT_W-1:0] tx_csum;
`endif

  assign tx_len_new = len_m1_of(bus.tx_data);
  assign tx_hdr_new = {TAG, tx_len_new, bus.tx_dest};

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next            = tx_state;
    bus.tx_ready       = 1'b0;
    bus.flit_out_valid = 1'b0;
    bus.flit_out       = '0;
    case (tx_state)
      TX_IDLE: begin
        bus.tx_ready = 1'b1;
        if (bus.tx_valid) tx_next = TX_HEAD;
      end
      TX_HEAD: begin
        bus.flit_out_valid = 1'b1;
        bus.flit_out       = tx_hdr;
        if (bus.flit_out_ready) tx_next = TX_DATA;
      end
      TX_DATA: begin
        bus.flit_out_valid = 1'b1;
        bus.flit_out       = tx_word[FLIT_W-1:0];
        if (bus.flit_out_ready && tx_cnt == tx_len_m1) begin
`ifdef NOC_NI_CSUM_EN
          tx_next = TX_CSUM;
`else
          tx_next = TX_TAIL;
`endif
        end
      end
`ifdef NOC_NI_CSUM_EN
      TX_CSUM: begin
        bus.flit_out_valid = 1'b1;
        bus.flit_out       = tx_csum;
        if (bus.flit_out_ready) tx_next = TX_TAIL;
      end
`endif
      TX_TAIL: begin
        bus.flit_out_valid = 1'b1;
        bus.flit_out       = TAIL_FLIT;
        if (bus.flit_out_ready) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_word   <= '0;
      tx_hdr    <= '0;
      tx_len_m1 <= '0;
      tx_cnt    <= '0;
`ifdef NOC_NI_CSUM_EN
      tx_csum   <= '0;
`endif
    end else begin
      if (tx_state == TX_IDLE && bus.tx_valid) begin
        tx_word   <= bus.tx_data;
        tx_hdr    <= tx_hdr_new;
        tx_len_m1 <= tx_len_new;
        tx_cnt    <= '0;
`ifdef NOC_NI_CSUM_EN
        tx_csum   <= tx_hdr_new ^ xor_flits(bus.tx_data);
`endif
      end else if (tx_state == TX_DATA && bus.flit_out_ready) begin
        tx_word <= tx_word >> FLIT_W;
        tx_cnt  <= tx_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- RX path
  typedef enum logic [2:0] {
    RX_HEAD, RX_DATA,
`ifdef NOC_NI_CSUM_EN
    RX_CSUM,
`endif
    RX_TAIL, RX_HOLD
  } rx_state_t;

  rx_state_t         rx_state, rx_next;
  logic [DATA_W-1:0] rx_data_r;
  logic [ADDR_W-1:0] rx_dest_r;
  logic [LEN_W-1:0]  rx_len_m1, rx_cnt;
  logic              rx_err_r;
  logic              rx_tag_ok;
`ifdef NOC_NI_CSUM_EN
  logic [FLIT_W-1:0] rx_csum;
`endif

  assign rx_tag_ok   = bus.flit_in[FLIT_W-1 -: T] == TAG;
  assign bus.rx_data = rx_data_r;
  assign bus.rx_dest = rx_dest_r;

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_HEAD;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next           = rx_state;
    bus.flit_in_ready = 1'b1;
    bus.rx_valid      = 1'b0;
    bus.rx_err        = 1'b0;
    case (rx_state)
      RX_HEAD: if (bus.flit_in_valid && rx_tag_ok) rx_next = RX_DATA;
      RX_DATA: begin
        if (bus.flit_in_valid && rx_cnt == rx_len_m1) begin
`ifdef NOC_NI_CSUM_EN
          rx_next = RX_CSUM;
`else
          rx_next = RX_TAIL;
`endif
        end
      end
`ifdef NOC_NI_CSUM_EN
      RX_CSUM: if (bus.flit_in_valid) rx_next = RX_TAIL;
`endif
      RX_TAIL: if (bus.flit_in_valid) rx_next = RX_HOLD;
      RX_HOLD: begin
        bus.flit_in_ready = 1'b0;
        bus.rx_valid      = 1'b1;
        bus.rx_err        = rx_err_r;
        if (bus.rx_ready) rx_next = RX_HEAD;
      end
      default: rx_next = RX_HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_r <= '0;
      rx_dest_r <= '0;
      rx_len_m1 <= '0;
      rx_cnt    <= '0;
      rx_err_r  <= 1'b0;
`ifdef NOC_NI_CSUM_EN
      rx_csum   <= '0;
`endif
    end else if (bus.flit_in_valid) begin
      case (rx_state)
        RX_HEAD: begin
          if (rx_tag_ok) begin
            rx_data_r <= '0;
            rx_dest_r <= bus.flit_in[ADDR_W-1:0];
            rx_len_m1 <= bus.flit_in[ADDR_W +: LEN_W];
            rx_cnt    <= '0;
            rx_err_r  <= 1'b0;
`ifdef NOC_NI_CSUM_EN
            rx_csum   <= bus.flit_in;
`endif
          end
        end
        RX_DATA: begin
          rx_data_r[rx_cnt*FLIT_W +: FLIT_W] <= bus.flit_in;
          rx_cnt <= rx_cnt + 1'b1;
`ifdef NOC_NI_CSUM_EN
          rx_csum <= rx_csum ^ bus.flit_in;
`endif
        end
`ifdef NOC_NI_CSUM_EN
        RX_CSUM: rx_err_r <= rx_err_r | (bus.flit_in != rx_csum);
`endif
        RX_TAIL: rx_err_r <= rx_err_r | (bus.flit_in != TAIL_FLIT);
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_noc_ni_param.sv
`default_nettype none
// tb_noc_ni_param -- scoreboard bench for the NI: TX flit streams, RX reassembly, reset, concurrency.
module tb_noc_ni_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_ni_param_if #(.DATA_W(32), .FLIT_W(8), .ADDR_W(2)) bus();

  noc_ni_param #(.DATA_W(32), .FLIT_W(8), .ADDR_W(2), .HDR_TAG(32'b1011)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  dest;
    logic        err;
  } rx_exp_t;

  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_stim_q[$];
  logic [7:0] pkt_q[$];
  rx_exp_t    rx_exp_q[$];

  // Reference packet builder for the default geometry (4 flits of 8 bits, tag 0xB).
  function automatic void build_pkt(input logic [31:0] d, input logic [1:0] dst);
    int lm1 = 0;
`ifdef NOC_NI_CSUM_EN
    logic [7:0] cs;
`endif
    pkt_q.delete();
    for (int i = 1; i < 4; i++) if (d[8*i +: 8] != 8'h00) lm1 = i;
    pkt_q.push_back({4'hB, 2'(lm1), dst});
    for (int i = 0; i <= lm1; i++) pkt_q.push_back(d[8*i +: 8]);
`ifdef NOC_NI_CSUM_EN
    cs = 8'h00;
    foreach (pkt_q[k]) cs ^= pkt_q[k];
    pkt_q.push_back(cs);
`endif
    pkt_q.push_back(8'hFF);
  endfunction

  // Called at a negedge with tx_exp_q loaded; returns at the negedge after the tail handshake.
  task automatic test_tx(input string name, input logic [31:0] d, input logic [1:0] dst,
                         input int stall_idx);
    int idx = 0;
    int guard = 0;
    logic [7:0] exp;
    bus.tx_data = d; bus.tx_dest = dst; bus.tx_valid = 1'b1; bus.flit_out_ready = 1'b1;
    checks++;
    if (bus.tx_ready !== 1'b1) begin
      errors++; $display("FAIL %s tx_ready_idle: got %b want 1", name, bus.tx_ready);
    end
    @(negedge clk);
    bus.tx_valid = 1'b0; bus.tx_data = $urandom; bus.tx_dest = 2'($urandom);
    while (tx_exp_q.size() > 0 && guard < 64) begin
      exp = tx_exp_q[0];
      checks++;
      if (bus.flit_out_valid !== 1'b1 || bus.flit_out !== exp) begin
        errors++;
        $display("FAIL %s flit%0d: got valid=%b flit=%h want valid=1 flit=%h",
                 name, idx, bus.flit_out_valid, bus.flit_out, exp);
      end
      if (idx == stall_idx) begin
        bus.flit_out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (bus.flit_out_valid !== 1'b1 || bus.flit_out !== exp) begin
            errors++;
            $display("FAIL %s stall_hold: got valid=%b flit=%h want valid=1 flit=%h",
                     name, bus.flit_out_valid, bus.flit_out, exp);
          end
        end
        bus.flit_out_ready = 1'b1;
      end
      void'(tx_exp_q.pop_front());
      idx++; guard++;
      @(negedge clk);
    end
    checks++;
    if (tx_exp_q.size() != 0) begin
      errors++; $display("FAIL %s timeout: %0d flits left want 0", name, tx_exp_q.size());
      tx_exp_q.delete();
    end
    checks++;
    if (bus.tx_ready !== 1'b1 || bus.flit_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_tail: got tx_ready=%b valid=%b want tx_ready=1 valid=0",
               name, bus.tx_ready, bus.flit_out_valid);
    end
  endtask

  // Called at a negedge with rx_stim_q and rx_exp_q loaded.
  task automatic test_rx(input string name, input int hold);
    rx_exp_t exp;
    int g = 0;
    bus.rx_ready = 1'b0;
    while (rx_stim_q.size() > 0) begin
      bus.flit_in = rx_stim_q.pop_front(); bus.flit_in_valid = 1'b1;
      checks++;
      if (bus.flit_in_ready !== 1'b1) begin
        errors++; $display("FAIL %s flit_in_ready: got %b want 1 (flit %h)", name, bus.flit_in_ready, bus.flit_in);
      end
      @(negedge clk);
    end
    bus.flit_in_valid = 1'b0; bus.flit_in = 8'h00;
    while (bus.rx_valid !== 1'b1 && g < 8) begin @(negedge clk); g++; end
    exp = rx_exp_q.pop_front();
    checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== exp.data || bus.rx_dest !== exp.dest || bus.rx_err !== exp.err) begin
      errors++;
      $display("FAIL %s rx_word: got valid=%b data=%h dest=%0d err=%b want valid=1 data=%h dest=%0d err=%b",
               name, bus.rx_valid, bus.rx_data, bus.rx_dest, bus.rx_err, exp.data, exp.dest, exp.err);
    end
    repeat (hold) begin
      @(negedge clk);
      checks++;
      if (bus.rx_valid !== 1'b1 || bus.flit_in_ready !== 1'b0 || bus.rx_data !== exp.data) begin
        errors++;
        $display("FAIL %s rx_hold: got valid=%b in_ready=%b data=%h want valid=1 in_ready=0 data=%h",
                 name, bus.rx_valid, bus.flit_in_ready, bus.rx_data, exp.data);
      end
    end
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    checks++;
    if (bus.rx_valid !== 1'b0 || bus.flit_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s rx_release: got valid=%b in_ready=%b want valid=0 in_ready=1",
               name, bus.rx_valid, bus.flit_in_ready);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (bus.tx_ready !== 1'b1 || bus.flit_out_valid !== 1'b0 || bus.flit_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx: got tx_ready=%b valid=%b flit=%h want 1 0 00",
               bus.tx_ready, bus.flit_out_valid, bus.flit_out);
    end
    checks++;
    if (bus.flit_in_ready !== 1'b1 || bus.rx_valid !== 1'b0 || bus.rx_err !== 1'b0 ||
        bus.rx_data !== 32'h0 || bus.rx_dest !== 2'd0) begin
      errors++;
      $display("FAIL reset_rx: got in_ready=%b valid=%b err=%b data=%h dest=%0d want 1 0 0 0 0",
               bus.flit_in_ready, bus.rx_valid, bus.rx_err, bus.rx_data, bus.rx_dest);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx_basic;
    tx_exp_q = '{8'hBE, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef NOC_NI_CSUM_EN
    tx_exp_q.push_back(8'hB6);
`endif
    tx_exp_q.push_back(8'hFF);
    test_tx("tx_basic", 32'h12345678, 2'd2, -1);
  endtask

  task automatic test_tx_short;
    tx_exp_q = '{8'hB1, 8'hA5};
`ifdef NOC_NI_CSUM_EN
    tx_exp_q.push_back(8'h14);
`endif
    tx_exp_q.push_back(8'hFF);
    test_tx("tx_short", 32'h000000A5, 2'd1, -1);
  endtask

  task automatic test_tx_stall;
    tx_exp_q = '{8'hBE, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef NOC_NI_CSUM_EN
    tx_exp_q.push_back(8'hB6);
`endif
    tx_exp_q.push_back(8'hFF);
    test_tx("tx_stall", 32'h12345678, 2'd2, 2);
  endtask

  task automatic test_tx_zero;
    tx_exp_q = '{8'hB3, 8'h00};
`ifdef NOC_NI_CSUM_EN
    tx_exp_q.push_back(8'hB3);
`endif
    tx_exp_q.push_back(8'hFF);
    test_tx("tx_zero", 32'h00000000, 2'd3, -1);
  endtask

  task automatic test_rx_hold;
    rx_stim_q = '{8'hB9, 8'h11, 8'h22, 8'h33};
`ifdef NOC_NI_CSUM_EN
    rx_stim_q.push_back(8'hB9);
`endif
    rx_stim_q.push_back(8'hFF);
    rx_exp_q.push_back('{data: 32'h00332211, dest: 2'd1, err: 1'b0});
    test_rx("rx_hold", 3);
  endtask

  task automatic test_rx_drop_err;
    rx_stim_q = '{8'h3E, 8'hB1, 8'h07};
`ifdef NOC_NI_CSUM_EN
    rx_stim_q.push_back(8'hB6);
`endif
    rx_stim_q.push_back(8'hFE);
    rx_exp_q.push_back('{data: 32'h00000007, dest: 2'd1, err: 1'b1});
    test_rx("rx_drop_err", 1);
  endtask

  // Reset lands mid-packet on both paths; neither may leak into later traffic.
  task automatic test_reset_mid;
    bus.tx_data = 32'hCAFEF00D; bus.tx_dest = 2'd3; bus.tx_valid = 1'b1; bus.flit_out_ready = 1'b1;
    bus.flit_in = 8'hB9; bus.flit_in_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0; bus.flit_in = 8'h11;
    checks++;
    if (bus.flit_out_valid !== 1'b1 || bus.flit_out !== 8'hBF) begin
      errors++;
      $display("FAIL reset_mid_hdr: got valid=%b flit=%h want valid=1 flit=bf", bus.flit_out_valid, bus.flit_out);
    end
    @(negedge clk);
    rst = 1'b1; bus.flit_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.flit_out_valid !== 1'b0 || bus.tx_ready !== 1'b1 || bus.flit_out !== 8'h00 ||
        bus.flit_in_ready !== 1'b1 || bus.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b tx_ready=%b flit=%h in_ready=%b rx_valid=%b want 0 1 00 1 0",
               bus.flit_out_valid, bus.tx_ready, bus.flit_out, bus.flit_in_ready, bus.rx_valid);
    end
    build_pkt(32'h0000BEEF, 2'd0);
    tx_exp_q = pkt_q;
    test_tx("reset_mid_tx", 32'h0000BEEF, 2'd0, -1);
    build_pkt(32'h00440000, 2'd2);
    rx_stim_q = pkt_q;
    rx_exp_q.push_back('{data: 32'h00440000, dest: 2'd2, err: 1'b0});
    test_rx("reset_mid_rx", 0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] words[4];
    logic [1:0]  dst;
    words = '{32'h00FF0000, 32'h01000000, $urandom & 32'h0000FFFF, $urandom};
    foreach (words[i]) begin
      dst = 2'(i);
      build_pkt(words[i], dst);
      tx_exp_q = pkt_q;
      test_tx("back_to_back", words[i], dst, (i == 3) ? 1 : -1);
    end
  endtask

  task automatic test_concurrent;
    logic [31:0] wt, wr;
    wt = $urandom | 32'h01000000;
    wr = $urandom & 32'h00FFFFFF;
    build_pkt(wt, 2'd1);
    tx_exp_q = pkt_q;
    build_pkt(wr, 2'd3);
    rx_stim_q = pkt_q;
    rx_exp_q.push_back('{data: wr, dest: 2'd3, err: 1'b0});
    fork
      test_tx("concurrent_tx", wt, 2'd1, 3);
      test_rx("concurrent_rx", 2);
    join
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.tx_data = '0; bus.tx_dest = '0; bus.tx_valid = 1'b0; bus.flit_out_ready = 1'b0;
    bus.flit_in = '0; bus.flit_in_valid = 1'b0; bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_tx_basic;
    test_tx_short;
    test_tx_stall;
    test_tx_zero;
    test_rx_hold;
    test_rx_drop_err;
    test_reset_mid;
    test_back_to_back;
    test_concurrent;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/noc_ni_param.md
NOC_NI_PARAM -- requirements
Module: noc_ni_param

Interface
REQ-001 Parameter DATA_W, default 32, processor word width; SHALL be an integer multiple of FLIT_W with N = DATA_W/FLIT_W >= 2.
REQ-002 Parameter FLIT_W, default 8, flit width.
REQ-003 Parameter ADDR_W, default 2, destination address width.
REQ-004 Parameter HDR_TAG, default 4'b1011, header tag of width T = FLIT_W-ADDR_W-LEN_W, where LEN_W = clog2(N); T SHALL be >= 1.
REQ-005 Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_W  word to send.
- tx_dest  in  ADDR_W  destination address.
- tx_valid  in  1  processor offers a word.
- tx_ready  out  1  NI accepts a word.
- flit_out  out  FLIT_W  flit to the router.
- flit_out_valid  out  1  flit_out is valid.
- flit_out_ready  in  1  router accepts the flit.
- flit_in  in  FLIT_W  flit from the router.
- flit_in_valid  in  1  flit_in is valid.
- flit_in_ready  out  1  NI accepts the flit.
- rx_data  out  DATA_W  received word.
- rx_dest  out  ADDR_W  address field of the received header.
- rx_valid  out  1  received word available.
- rx_ready  in  1  processor takes the word.
- rx_err  out  1  received packet is malformed; qualified by rx_valid.

Function
REQ-006 A handshake SHALL complete on a cycle where valid && ready; on every interface, valid and data SHALL hold stable until that cycle.
REQ-007 Packet format SHALL be: header {HDR_TAG, L-1, dest}, then L payload flits (least-significant flit first), then tail (all ones).
REQ-008 L SHALL be 1 + the index of the highest nonzero payload flit; a zero word gives L = 1.
REQ-009 The TX FSM SHALL have the states IDLE -> HEAD -> DATA -> [CSUM] -> TAIL -> IDLE.
- tx_ready = 1 only in IDLE.
- flit_out_valid = 1 only in HEAD, DATA, CSUM and TAIL.
- The FSM advances on each flit_out handshake.
REQ-010 After a tx handshake in cycle c, the header SHALL be valid in cycle c+1; with flit_out_ready held high, the packet SHALL take L+2 cycles and tx_ready SHALL rise in the cycle after the tail handshake.
REQ-011 The RX FSM SHALL have the states HEAD -> DATA -> [CSUM] -> TAIL -> HOLD -> HEAD.
- flit_in_ready = 1 in every state except HOLD.
- rx_valid = 1 only in HOLD.
REQ-012 In HEAD, a flit whose tag is not HDR_TAG SHALL be consumed and discarded; the FSM stays in HEAD and raises no error.
REQ-013 The payload flits that were not received SHALL be zero in rx_data.
REQ-014 rx_err SHALL be 1 in HOLD if the tail flit is not all ones, or on a checksum mismatch (REQ-018).
REQ-015 HOLD SHALL exit to HEAD on rx_ready; a packet whose tail arrives while HOLD is occupied is impossible, because flit_in_ready = 0 there.
REQ-016 The TX and RX paths SHALL be fully independent; simultaneous activity on both SHALL not interact.

Reset
REQ-017 While rst is high at a clock edge, the block SHALL set:
- both FSMs to IDLE/HEAD;
- tx_ready = 1;
- flit_out_valid = 0, flit_out = 0;
- flit_in_ready = 1;
- rx_valid = 0, rx_err = 0, rx_data = 0, rx_dest = 0.
Any packet in flight, including one reset mid-packet, SHALL be discarded.

Configuration
REQ-018 Macro NOC_NI_CSUM_EN:
- Defined: a CSUM flit equal to the XOR of the header and all L payload flits SHALL precede the tail. The receiver SHALL compute the same XOR and set rx_err on a mismatch. Packet length becomes L+3.
- Undefined: the CSUM states are absent.

Verification (defaults, macro undefined unless noted)
REQ-019 tx_data=0x12345678, tx_dest=2, flit_out_ready=1 -> flits 0xBE,0x78,0x56,0x34,0x12,0xFF on consecutive cycles; tx_ready=1 the cycle after 0xFF.
REQ-020 tx_data=0x000000A5, tx_dest=1 -> 0xB1,0xA5,0xFF. With NOC_NI_CSUM_EN -> 0xB1,0xA5,0x14,0xFF.
REQ-021 flit_out_ready low for 3 cycles while 0x56 is presented -> 0x56 and flit_out_valid held; the sequence then resumes unchanged.
REQ-022 flit_in 0xB9,0x11,0x22,0x33,0xFF with rx_ready=0 -> rx_data=0x00332211, rx_dest=1, rx_valid=1 and flit_in_ready=0 held until rx_ready=1.
REQ-023 flit_in 0x3E (dropped), then 0xB1,0x07,0xFE -> rx_data=0x00000007, rx_err=1 with rx_valid.
REQ-024 rst asserted the cycle after the header handshake -> next cycle flit_out_valid=0, tx_ready=1; a new word is then sent correctly.
